// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } state_t;

  // Saturation value of a w-bit counter (all ones).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain plus one edge-detect flop; rise and fall share the same delay.
module pwm_sync_edge #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_N-1:0] sync;
  logic              s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_N-2:0], d};
      s_d  <= sync[SYNC_N-1];
    end
  end

  assign s    = sync[SYNC_N-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of pwm_in, one report per period, with stuck detection.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int SYNC_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             s, rise, fall;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_snap;

  pwm_sync_edge #(.SYNC_N(SYNC_N)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_snap     <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise)               cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, STUCK: if (rise) state <= HIGH;
          HIGH: begin
            if (fall) begin
              hi_snap <= cnt;
              state   <= LOW;
            end else if (cnt == CNT_MAX) begin
              high_cnt    <= s ? CNT_MAX : '0;
              period_cnt  <= CNT_MAX;
              stuck       <= 1'b1;
              stuck_level <= s;
              valid       <= 1'b1;
              state       <= STUCK;
            end
          end
          LOW: begin
            // A rise on the saturation cycle still counts as a real period.
            if (rise) begin
              high_cnt   <= hi_snap;
              period_cnt <= cnt;
              stuck      <= 1'b0;
              valid      <= 1'b1;
              state      <= HIGH;
            end else if (cnt == CNT_MAX) begin
              high_cnt    <= s ? CNT_MAX : '0;
              period_cnt  <= CNT_MAX;
              stuck       <= 1'b1;
              stuck_level <= s;
              valid       <= 1'b1;
              state       <= STUCK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench: a 256-cycle PWM generator model drives pwm_in; reports are collected and checked.
module tb_pwm_capture;
  localparam int CNT_W  = 10;
  localparam int SYNC_N = 2;

  logic             clk = 1'b0;
  logic             rst_n, en, pwm_in;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             valid, stuck, stuck_level;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_N(SYNC_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  typedef struct {
    int hi;
    int per;
    int stk;
    int lvl;
  } rep_t;

  typedef struct {
    int val;
    int exp_hi;
    int exp_per;
  } vec_t;

  rep_t reps[$];
  int   tests = 0, fails = 0;
  int   phase = 0, gen_val = 128, cur_val = 128;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then advance the generator.
  task automatic step();
    @(negedge clk);
    if (valid) begin
      check("valid_not_back_to_back", 32'(prev_valid), 0);
      reps.push_back('{int'(high_cnt), int'(period_cnt), int'(stuck), int'(stuck_level)});
    end
    prev_valid = valid;
    phase = (phase == 255) ? 0 : phase + 1;
    if (phase == 0) cur_val = gen_val;
    pwm_in = (phase < cur_val);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < 300 && phase != p; i++) step();
    check("phase_align", phase, p);
  endtask

  task automatic check_rep(input string name, input int idx, input int hi, input int per,
                           input int stk, input int lvl);
    if (idx >= reps.size()) begin
      tests++; fails++;
      $display("FAIL %s: report %0d missing, got %0d reports", name, idx, reps.size());
    end else begin
      check({name, "_high"},   reps[idx].hi,  hi);
      check({name, "_period"}, reps[idx].per, per);
      check({name, "_stuck"},  reps[idx].stk, stk);
      if (stk != 0) check({name, "_level"}, reps[idx].lvl, lvl);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{128, 128, 256};
    vecs[1] = '{1,   1,   256};
    vecs[2] = '{255, 255, 256};
    vecs[3] = '{10,  10,  256};
    vecs[4] = '{200, 200, 256};
    vecs[5] = '{64,  64,  256};

    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b1;
    #1;
    check("rst_high_cnt",   high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_valid",      valid, 0);
    check("rst_stuck",      stuck, 0);
    check("rst_level",      stuck_level, 0);
    run(3);
    rst_n = 1'b1;

    // Steady-state loopback for each duty value
    foreach (vecs[k]) begin
      gen_val = vecs[k].val;
      run(600);
      run_to_phase(20);
      reps.delete();
      run(512);
      check($sformatf("v%0d_count", vecs[k].val), reps.size(), 2);
      for (int r = 0; r < 2; r++)
        check_rep($sformatf("v%0d_r%0d", vecs[k].val, r), r, vecs[k].exp_hi, vecs[k].exp_per, 0, 0);
    end

    // Value change mid-period: old value finishes its period, then new value
    run_to_phase(100);
    gen_val = 200;
    reps.delete();
    run(432);
    check("chg_count", reps.size(), 2);
    check_rep("chg_trans", 0, 64, 256, 0, 0);
    check_rep("chg_new",   1, 200, 256, 0, 0);

    // en dropped mid-period
    gen_val = 128;
    run(600);
    run_to_phase(50);
    reps.delete();
    en = 1'b0;
    run(10);
    check("en_hold_high",   high_cnt, 128);
    check("en_hold_period", period_cnt, 256);
    en = 1'b1;
    run_to_phase(20);
    check("en_no_report_span", reps.size(), 0);
    run(256);
    check("en_resume_count", reps.size(), 1);
    check_rep("en_resume", 0, 128, 256, 0, 0);

    // Reset pulsed mid-HIGH, released while input is low
    run_to_phase(30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_high_cnt",   high_cnt, 0);
    check("mid_rst_period_cnt", period_cnt, 0);
    check("mid_rst_valid",      valid, 0);
    run_to_phase(150);
    rst_n = 1'b1;
    reps.delete();
    run_to_phase(20);
    check("rst_no_early_report", reps.size(), 0);
    run(256);
    check("rst_resume_count", reps.size(), 1);
    check_rep("rst_resume", 0, 128, 256, 0, 0);

    // Constant low -> single stuck report, then silence
    gen_val = 0;
    reps.delete();
    run(1300);
    check("stuck_lo_count", reps.size(), 1);
    check_rep("stuck_lo", 0, 0, 1023, 1, 0);
    reps.delete();
    run(600);
    check("stuck_lo_silent", reps.size(), 0);

    // Constant high -> stuck level 1
    gen_val = 256;
    run(1400);
    check("stuck_hi_count", reps.size(), 1);
    check_rep("stuck_hi", 0, 1023, 1023, 1, 1);

    // Recovery from stuck-high
    gen_val = 128;
    run_to_phase(20);
    reps.delete();
    run(512);
    check("recover_count", reps.size(), 1);
    check_rep("recover", 0, 128, 256, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
